pe_operand_seq: RTL

PE_OPERAND_SEQ -- requirements
Module: pe_operand_seq

---
 rtl/pe_pkg.sv | 9 +
 rtl/pe_operand_seq.sv | 105 ++++++++++
 2 files changed

// File: rtl/pe_pkg.sv
// Shared types for the processing-element operand path.
package pe_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    SWEEP = 1'b1
  } pe_state_e;

endpackage

// File: rtl/pe_operand_seq.sv
// Operand sequencer: fills an N_IN-word bank from a valid/ready stream, then
// sweeps a select across it for a downstream pe_mux, pulsing done at the end.
module pe_operand_seq
  import pe_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned SEL_WIDTH = 3,
  localparam int unsigned N_IN      = 2 ** SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [WIDTH-1:0]     data_bank [N_IN-1:0],
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 sel_valid,
  input  logic                 sel_ready,
  output logic                 done
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N_IN - 1);
  localparam logic [SEL_WIDTH-1:0] ONE      = SEL_WIDTH'(1);

  pe_state_e            r_state;
  logic [SEL_WIDTH-1:0] r_wr_ptr;
  logic [SEL_WIDTH-1:0] r_sel;
  logic                 r_in_ready;
  logic                 r_sel_valid;
  logic                 r_done;
  logic [WIDTH-1:0]     r_bank [N_IN-1:0];

  logic w_in_hs;
  logic w_sel_hs;

  assign w_in_hs  = in_valid && r_in_ready;
  assign w_sel_hs = r_sel_valid && sel_ready;

  // Single-process FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_wr_ptr    <= '0;
      r_sel       <= '0;
      r_in_ready  <= 1'b1;
      r_sel_valid <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < int'(N_IN); i++) begin
        r_bank[i] <= '0;
      end
    end else if (clear) begin
      // Abort keeps the bank contents; only progress is discarded.
      r_state     <= LOAD;
      r_wr_ptr    <= '0;
      r_sel       <= '0;
      r_in_ready  <= 1'b1;
      r_sel_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_in_hs) begin
            r_bank[r_wr_ptr] <= in_data;
            if (r_wr_ptr == LAST_IDX) begin
              r_state     <= SWEEP;
              r_wr_ptr    <= '0;
              r_sel       <= '0;
              r_in_ready  <= 1'b0;
              r_sel_valid <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + ONE;
            end
          end
        end
        SWEEP: begin
          if (w_sel_hs) begin
            // Final selection stays on the last index rather than wrapping.
            if (r_sel == LAST_IDX) begin
              r_state     <= LOAD;
              r_in_ready  <= 1'b1;
              r_sel_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_sel <= r_sel + ONE;
            end
          end
        end
        default: begin
          r_state     <= LOAD;
          r_in_ready  <= 1'b1;
          r_sel_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign sel_valid = r_sel_valid;
  assign sel       = r_sel;
  assign done      = r_done;
  assign data_bank = r_bank;

endmodule
